// File: rtl/alu_seq_muldiv_if.sv
// Request/response bundle between the execute-stage controller and alu_seq_muldiv.
// Signal names are written from the ALU's point of view (_i into the ALU, _o out of it).
// Ports: request (valid_i/ready_o, ALUop_i, funct_i, srcA_i, srcB_i); response
// (valid_o, aluResult_o, zero_o); status (hi_o, lo_o, busy_o). Modport slave = ALU side.
interface alu_seq_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [1:0]       ALUop_i;
  logic [5:0]       funct_i;
  logic [WIDTH-1:0] srcA_i;
  logic [WIDTH-1:0] srcB_i;
  logic             valid_o;
  logic [WIDTH-1:0] aluResult_o;
  logic             zero_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             busy_o;

  modport slave (
    input  valid_i, ALUop_i, funct_i, srcA_i, srcB_i,
    output ready_o, valid_o, aluResult_o, zero_o, hi_o, lo_o, busy_o
  );

  modport master (
    output valid_i, ALUop_i, funct_i, srcA_i, srcB_i,
    input  ready_o, valid_o, aluResult_o, zero_o, hi_o, lo_o, busy_o
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Registered MIPS execute-stage ALU with funct decode, HI/LO and iterative unsigned multu/divu.
// Latency: single-cycle ops valid one cycle after accept; multu/divu WIDTH+1 cycles (divu by 0: 2).
// Backpressure: ready_o drops while a mul/div iterates; valid_i is ignored then.
// Ports: clk_i, rst_i (sync, active-high), bus (alu_seq_muldiv_if.slave), and
// ovf_o (signed add/sub overflow) only when ALU_SEQ_OVF_EN is defined.
module alu_seq_muldiv #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  alu_seq_muldiv_if.slave      bus
`ifdef ALU_SEQ_OVF_EN
  , output logic               ovf_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MULT = 6'b011001;
  localparam logic [5:0] F_DIVU = 6'b011011;

  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  // Working registers for the iteration: acc_hi = partial product / remainder,
  // acc_lo = multiplier being shifted out / dividend shifting into quotient.
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ready, accept, op_mul, op_div, last_step;
  logic [WIDTH-1:0] add_res, sub_res, alu_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] div_shift, div_rem;
  logic             div_ge;

  assign ready     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept    = bus.valid_i && ready;
  assign add_res   = bus.srcA_i + bus.srcB_i;
  assign sub_res   = bus.srcA_i - bus.srcB_i;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // One shift-add step: conditionally add B to the high half, then shift {sum, lo} right.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

  // One restoring step: shift next dividend bit into the remainder. The bit shifted out
  // of acc_hi only takes part in the compare; the true remainder always fits in WIDTH.
  assign div_shift = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
  assign div_ge    = {acc_hi_q[WIDTH-1], div_shift} >= {1'b0, opb_q};
  assign div_rem   = div_ge ? (div_shift - opb_q) : div_shift;

  // Funct/ALUop decode for the single-cycle path.
  always_comb begin
    alu_res = '0;
    op_mul  = 1'b0;
    op_div  = 1'b0;
    case (bus.ALUop_i)
      2'b00: alu_res = add_res;
      2'b01: alu_res = sub_res;
      2'b10: begin
        case (bus.funct_i)
          F_ADD:  alu_res = add_res;
          F_SUB:  alu_res = sub_res;
          F_AND:  alu_res = bus.srcA_i & bus.srcB_i;
          F_OR:   alu_res = bus.srcA_i | bus.srcB_i;
          F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.srcA_i) < $signed(bus.srcB_i)};
          F_MFHI: alu_res = hi_q;
          F_MFLO: alu_res = lo_q;
          F_MULT: op_mul  = 1'b1;
          F_DIVU: op_div  = 1'b1;
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SEQ_OVF_EN
  logic ovf_q, ovf_d, ovf_now;
  always_comb begin
    ovf_now = 1'b0;
    if (bus.ALUop_i == 2'b00 || (bus.ALUop_i == 2'b10 && bus.funct_i == F_ADD))
      ovf_now = (bus.srcA_i[WIDTH-1] == bus.srcB_i[WIDTH-1]) &&
                (add_res[WIDTH-1] != bus.srcA_i[WIDTH-1]);
    else if (bus.ALUop_i == 2'b01 || (bus.ALUop_i == 2'b10 && bus.funct_i == F_SUB))
      ovf_now = (bus.srcA_i[WIDTH-1] != bus.srcB_i[WIDTH-1]) &&
                (sub_res[WIDTH-1] != bus.srcA_i[WIDTH-1]);
  end
`endif

  // Next-state / datapath control.
  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
`ifdef ALU_SEQ_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE is a one-cycle result slot; it accepts new work exactly like IDLE.
        state_d = S_IDLE;
        if (accept) begin
          if (op_mul || op_div) begin
            state_d  = op_mul ? S_MUL : S_DIV;
            acc_hi_d = '0;
            acc_lo_d = bus.srcA_i;
            opb_d    = bus.srcB_i;
            cnt_d    = '0;
          end else begin
            valid_d  = 1'b1;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
`ifdef ALU_SEQ_OVF_EN
            ovf_d    = ovf_now;
`endif
          end
        end
      end
      S_MUL: begin
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_step) begin
          state_d  = S_DONE;
          valid_d  = 1'b1;
          hi_d     = acc_hi_d;
          lo_d     = acc_lo_d;
          result_d = acc_lo_d;
          zero_d   = (acc_lo_d == '0);
`ifdef ALU_SEQ_OVF_EN
          ovf_d    = 1'b0;
`endif
        end
      end
      S_DIV: begin
        if (opb_q == '0) begin
          // Divide by zero short-circuits: quotient all ones, remainder = dividend.
          state_d  = S_DONE;
          valid_d  = 1'b1;
          hi_d     = acc_lo_q;
          lo_d     = '1;
          result_d = '1;
          zero_d   = 1'b0;
`ifdef ALU_SEQ_OVF_EN
          ovf_d    = 1'b0;
`endif
        end else begin
          acc_hi_d = div_rem;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
          cnt_d    = cnt_q + CNT_W'(1);
          if (last_step) begin
            state_d  = S_DONE;
            valid_d  = 1'b1;
            hi_d     = acc_hi_d;
            lo_d     = acc_lo_d;
            result_d = acc_lo_d;
            zero_d   = (acc_lo_d == '0);
`ifdef ALU_SEQ_OVF_EN
            ovf_d    = 1'b0;
`endif
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
`ifdef ALU_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
`ifdef ALU_SEQ_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.ready_o     = ready;
  assign bus.busy_o      = (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.valid_o     = valid_q;
  assign bus.aluResult_o = result_q;
  assign bus.zero_o      = zero_q;
  assign bus.hi_o        = hi_q;
  assign bus.lo_o        = lo_q;
`ifdef ALU_SEQ_OVF_EN
  assign ovf_o = ovf_q;
`endif

endmodule

// File: doc/alu_seq_muldiv.md
Name: alu_seq_muldiv

Overview:
- Parametrised, registered successor to the single-cycle MIPS ALU + ALUControl pair.
- Merges funct decode and datapath; adds valid/ready input handshake, registered outputs, iterative unsigned multiply/divide, HI/LO registers.
- Sits in the execute stage of the multi-cycle MIPS core; the controller stalls on ready_o.

Parameters:
- WIDTH, 32, operand/result width (>=4)
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  operation request
- ready_o  out  1  block accepts a request this cycle
- ALUop_i  in  2  main-decoder ALU op
- funct_i  in  6  R-type funct field
- srcA_i  in  WIDTH  operand A
- srcB_i  in  WIDTH  operand B
- valid_o  out  1  one-cycle pulse, result valid
- aluResult_o  out  WIDTH  registered result
- zero_o  out  1  registered (aluResult_o == 0)
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register
- busy_o  out  1  mul/div in progress

Behaviour:
- Reset: state IDLE; ready_o=1; valid_o=0; aluResult_o=0; zero_o=1; hi_o=lo_o=0; busy_o=0; counter=0.
- Accept on rising edge with valid_i && ready_o; operands, ALUop_i and funct_i captured at that edge.
- Decode:
  - ALUop 00 -> add; 01 -> sub; 11 -> result 0.
  - ALUop 10 -> funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 1/0 zero-extended), 010000 mfhi, 010010 mflo, 011001 multu, 011011 divu; any other funct -> result 0.
- Arithmetic: add/sub wrap modulo 2^WIDTH, no overflow flag.
- Single-cycle ops:
  - Result and zero_o registered at the accept edge; valid_o high for the following cycle only.
  - ready_o stays 1, so back-to-back issue every cycle is allowed.
- FSM: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL on accepted multu; IDLE -> DIV on accepted divu.
  - MUL/DIV: one shift-add (MUL) or restoring shift-subtract (DIV) step per clock for WIDTH clocks; ready_o=0, busy_o=1; valid_i ignored.
  - After the WIDTH-th step -> DONE; HI/LO are written on that edge.
  - DONE: valid_o=1 for one cycle; aluResult_o = new LO; zero_o per LO; then -> IDLE.
  - Latency from accept edge to valid_o cycle is WIDTH+1 cycles.
- Results: multu -> {HI,LO} = A*B (2*WIDTH-bit unsigned). divu -> LO = quotient, HI = remainder.
- divu with B=0: no iteration; DONE next cycle; LO = all ones, HI = A.
- mfhi/mflo issued right after valid_o of a mul/div return the new HI/LO.
- HI/LO change only at mul/div completion or reset.
- rst_i asserted mid-MUL/DIV: abort at that edge; all state and outputs return to reset values; no valid_o pulse.
- aluResult_o and zero_o hold their last value between valid_o pulses.

Optional Feature:
- Macro: ALU_SEQ_OVF_EN.
- Defined:
  - Adds output ovf_o (1 bit, reset 0).
  - Registered alongside aluResult_o; 1 when signed add (ALUop 00 / funct 100000) or signed sub (ALUop 01 / funct 100010) overflows, else 0.
  - Meaningful only while valid_o=1; result is still written (wrapped).
- Not defined: port absent; no overflow logic.

Test Plan:
- Reset then ALUop=00, A=0x9, B=0x2 -> next cycle valid_o=1, aluResult_o=0xB, zero_o=0; ready_o stays 1.
- Back-to-back ALUop=10 on A=0x16, B=0x4, funct 100010/100100/100101 -> results 0x12, 0x4, 0x16 on three consecutive valid_o cycles.
- funct 101010, A=B=0x10 -> result 0, zero_o=1; A=0xFFFFFFFF, B=0x1 -> result 1.
- multu A=0xFFFFFFFF, B=0x2 -> ready_o low 32 cycles; valid_o in cycle 33 after accept; HI=0x1, LO=0xFFFFFFFE; then mfhi -> 0x1.
- divu A=0x16, B=0x4 -> LO=0x5, HI=0x2; divu B=0 -> valid_o 2 cycles after accept, LO=0xFFFFFFFF, HI=0x16.
- rst_i pulsed 10 cycles into multu -> no valid_o; next cycle ready_o=1, HI=LO=0; with ALU_SEQ_OVF_EN, add 0x7FFFFFFF+1 -> ovf_o=1, result 0x80000000.
